// File: rtl/cpu0_pkg.sv
// cpu0_pkg: shared definitions for the cpu0 instruction feeder.
//   INSTR_W / PC_W : host instruction and program-counter widths
//   OP_*           : host opcodes in instr[15:12]
//   state_e        : feeder FSM states
package cpu0_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 13;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/cpu0_predecode.sv
// cpu0_predecode: combinational control-flow predecode of one issued word.
//   word     in   16  instruction being issued
//   ptr      in   AW  RAM address of that instruction
//   next_ptr out  AW  address of the next word to issue
//   is_halt  out  1   word is HALT (feeder stops issuing)
//   is_jump  out  1   word is JUMP (next_ptr = target mod DEPTH)
module cpu0_predecode
    import cpu0_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [INSTR_W-1:0] word,
    input  logic [AW-1:0]      ptr,
    output logic [AW-1:0]      next_ptr,
    output logic               is_halt,
    output logic               is_jump
);

    // Operand bits above AW are irrelevant: jump targets wrap modulo DEPTH.
    logic unused_operand;
    assign unused_operand = ^word;

    always_comb begin
        is_jump  = (opcode_of(word) == OP_JMP);
        is_halt  = (opcode_of(word) == OP_HLT);
        next_ptr = ptr + AW'(1);
        if (is_jump) begin
            next_ptr = word[AW-1:0];
        end else if (is_halt) begin
            next_ptr = ptr;
        end
    end

endmodule

// File: rtl/cpu0_instr_feeder.sv
// cpu0_instr_feeder: program RAM plus issue sequencer feeding the cpu0 host.
// Streams RAM words on instruction/instr_valid, following JUMP and stopping at HALT.
//   clk, pon_rst_i             clock, synchronous active-high reset
//   load_en/load_addr/load_data RAM write port (IDLE/DONE only)
//   start, stop, cpu_halt_i    sequencing controls
//   pc_in                      host pc_out, checked only with CPU0_PC_CHECK_EN
//   instruction, instr_valid, fetch_addr   issued word, strobe and its RAM address
//   busy, done, issue_count, pc_mismatch   status
// Optional build macro: CPU0_PC_CHECK_EN enables the host PC cross-check.
module cpu0_instr_feeder
    import cpu0_pkg::*;
#(
    parameter  int DEPTH     = 256,
    parameter  int ISSUE_GAP = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               pon_rst_i,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               stop,
    input  logic               cpu_halt_i,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    fetch_addr,
    output logic               busy,
    output logic               done,
    output logic [15:0]        issue_count,
    output logic               pc_mismatch
);

    localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    state_e             state;
    logic [AW-1:0]      ptr;
    logic [GW-1:0]      gap_cnt;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               idle_or_done;
    logic               start_ok;
    logic               load_ok;
    logic               issue;
    logic [AW-1:0]      issue_addr;
    logic [INSTR_W-1:0] issue_word;
    logic [AW-1:0]      next_ptr;
    logic               is_halt;
    logic               is_jump;
    logic [15:0]        count_base;
    logic [15:0]        count_next;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign start_ok     = start && !stop && idle_or_done;
    assign load_ok      = load_en && !stop && idle_or_done;

    // start issues RAM[0] on the same edge so the first strobe follows start by one cycle.
    assign issue      = start_ok ||
                        ((state == RUN) && !stop && !cpu_halt_i && (gap_cnt == '0));
    assign issue_addr = start_ok ? '0 : ptr;
    // Write-first bypass: a load landing together with start is visible to the first issue.
    assign issue_word = (load_ok && (load_addr == issue_addr)) ? load_data : mem[issue_addr];

    assign count_base = start_ok ? 16'h0000 : issue_count;
    assign count_next = (count_base == 16'hFFFF) ? 16'hFFFF : count_base + 16'h0001;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    cpu0_predecode #(.AW(AW)) u_predecode (
        .word     (issue_word),
        .ptr      (issue_addr),
        .next_ptr (next_ptr),
        .is_halt  (is_halt),
        .is_jump  (is_jump)
    );

    logic unused_jump;
    assign unused_jump = is_jump;

    // RAM is deliberately not reset so a program survives pon_rst_i.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            gap_cnt     <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            fetch_addr  <= '0;
            issue_count <= '0;
        end else begin
            instr_valid <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else if (issue) begin
                instruction <= issue_word;
                instr_valid <= 1'b1;
                fetch_addr  <= PC_W'(issue_addr);
                ptr         <= next_ptr;
                gap_cnt     <= GW'(ISSUE_GAP);
                issue_count <= count_next;
                state       <= is_halt ? DRAIN : RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (cpu_halt_i) begin
                            state <= DONE;
                        end else if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                    DRAIN: begin
                        if (cpu_halt_i) begin
                            state <= DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CPU0_PC_CHECK_EN
    // Two-stage shadow of the PC the host should hold after each issued word,
    // aligned with the host's PC register plus its pc_out register.
    logic            s0_v, s1_v;
    logic [PC_W-1:0] s0_pc, s1_pc;
    logic [1:0]      sup_cnt;

    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            s0_v        <= 1'b0;
            s1_v        <= 1'b0;
            s0_pc       <= '0;
            s1_pc       <= '0;
            sup_cnt     <= '0;
            pc_mismatch <= 1'b0;
        end else if (start_ok) begin
            s0_v        <= 1'b1;
            s0_pc       <= PC_W'(next_ptr);
            s1_v        <= 1'b0;
            sup_cnt     <= 2'd2;
            pc_mismatch <= 1'b0;
        end else begin
            s0_v  <= issue;
            s0_pc <= PC_W'(next_ptr);
            s1_v  <= s0_v && !stop;
            s1_pc <= s0_pc;
            if (sup_cnt != 2'd0) begin
                sup_cnt <= sup_cnt - 2'd1;
            end else if (s1_v && (pc_in != s1_pc)) begin
                pc_mismatch <= 1'b1;
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc   = ^pc_in;
    assign pc_mismatch = 1'b0;
`endif

endmodule
